imem_loader: RTL and testbench

- Writer side of the instruction memory: fills the CPU's 32-entry word instruction memory from a byte stream, then releases the CPU from reset.
- Hardware equivalent of the bench's clear-then-load program sequence.
- Sits between the host byte source and the IM write port.
- Drives the CPU's active-low reset, so the core never fetches a partially loaded program.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_word_assembler.sv | 66 ++++++
 rtl/imem_loader.sv | 179 +++++++++++++++++
 tb/tb_imem_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Purpose: shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    localparam int IM_ADDR_W      = 5;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / 8;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Instruction memory depth in words for a given word-address width.
    function automatic int im_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Purpose: packs little-endian stream bytes into words; flush emits a zero-padded partial word.
// Latency: word_vld_o/word_dat_o are combinational in the cycle the completing byte (or flush) arrives.
// Backpressure: none; every byte_vld_i is consumed, the parent gates acceptance.
// Ports: clear_i drops any partial word; byte_vld_i/byte_dat_i feed one byte; flush_i forces
//        out a partial word; word_vld_o/word_dat_o carry the finished word; lane_o = bytes held.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_dat_i,
    input  logic              flush_i,
    output logic              word_vld_o,
    output logic [DATA_W-1:0] word_dat_o,
    output logic [LANE_W-1:0] lane_o
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    always_comb begin
        lane_d     = lane_q;
        acc_d      = acc_q;
        word_vld_o = 1'b0;
        word_dat_o = acc_q;
        if (clear_i) begin
            lane_d = '0;
            acc_d  = '0;
        end else if (byte_vld_i) begin
            // Lanes above lane_q are still zero, so OR-ing merges the new byte in place.
            word_dat_o = acc_q | (DATA_W'(byte_dat_i) << {lane_q, 3'b000});
            if (lane_q == LAST_LANE) begin
                word_vld_o = 1'b1;
                lane_d     = '0;
                acc_d      = '0;
            end else begin
                lane_d = lane_q + LANE_ONE;
                acc_d  = word_dat_o;
            end
        end else if (flush_i && (lane_q != '0)) begin
            word_vld_o = 1'b1;
            lane_d     = '0;
            acc_d      = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
    end

    assign lane_o = lane_q;

endmodule

// File: rtl/imem_loader.sv
// Purpose: clears the CPU instruction memory, loads it from a byte stream, then releases CPU reset.
// Latency: IM write one cycle after the 4th byte of a word; CLEAR takes 2^ADDR_W cycles.
// Backpressure: byte_ready_o is high only in LOAD; bytes offered elsewhere are ignored.
// Ports: start_i pulse (IDLE/DONE only); byte_valid_i/byte_i/last_i/byte_ready_o stream input;
//        imem_we_o/imem_addr_o/imem_wdata_o IM write port; cpu_rst_n_o, busy_o, done_o,
//        err_o (sticky overflow) and word_count_o status, all registered.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    input  logic              last_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_wdata_o,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam int             DEPTH   = im_depth(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clr_q, clr_d;
    logic [ADDR_W:0]   idx_q, idx_d;      // word index, doubles as word_count_o
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              asm_clear, asm_byte_vld, asm_flush;
    logic              asm_word_vld;
    logic [DATA_W-1:0] asm_word_dat;
    logic [LANE_W-1:0] asm_lane;

    imem_loader_word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (asm_clear),
        .byte_vld_i (asm_byte_vld),
        .byte_dat_i (byte_i),
        .flush_i    (asm_flush),
        .word_vld_o (asm_word_vld),
        .word_dat_o (asm_word_dat),
        .lane_o     (asm_lane)
    );

    assign accept = byte_valid_i & ready_q;

    always_comb begin
        state_d      = state_q;
        clr_d        = clr_q;
        idx_d        = idx_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ready_d      = 1'b0;
        err_d        = err_q;
        asm_clear    = 1'b0;
        asm_byte_vld = 1'b0;
        asm_flush    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    // First clear write (address 0) is issued on the start edge.
                    state_d   = ST_CLEAR;
                    we_d      = 1'b1;
                    addr_d    = '0;
                    wdata_d   = '0;
                    clr_d     = ONE_C;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    asm_clear = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_q == DEPTH_C) begin
                    state_d = ST_LOAD;
                    ready_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = clr_q[ADDR_W-1:0];
                    clr_d  = clr_q + ONE_C;
                end
            end
            ST_LOAD: begin
                ready_d = 1'b1;
                if (accept) begin
                    // Memory full: swallow the byte so the stream still drains to last_i.
                    if (idx_q == DEPTH_C) err_d = 1'b1;
                    else                  asm_byte_vld = 1'b1;
                    if (last_i) begin
                        state_d = ST_FLUSH;
                        ready_d = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                // Every load ends here so DONE (and CPU release) always follows the
                // cycle of the final write: a partial word is emitted and we linger one
                // more cycle; with nothing pending we leave straight away.
                asm_flush = 1'b1;
                if (!asm_word_vld) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (asm_word_vld) begin
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_W-1:0];
            wdata_d = asm_word_dat;
            idx_d   = idx_q + ONE_C;
        end

        busy_d      = (state_d == ST_CLEAR) || (state_d == ST_LOAD) || (state_d == ST_FLUSH);
        done_d      = (state_d == ST_DONE);
        cpu_rst_n_d = done_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            clr_q       <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_rst_n_o  = cpu_rst_n_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign word_count_o = idx_q;

    // Lane count is only needed inside the assembler's flush decision.
    logic unused_lane;
    assign unused_lane = ^asm_lane;

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: directed self-checking bench for imem_loader with a write-capturing IM model.
// Latency: n/a.
// Backpressure: stream driver waits on byte_ready_o with a bounded cycle budget.
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        last_i;
    logic        byte_ready_o;
    logic        imem_we_o;
    logic [4:0]  imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        cpu_rst_n_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [5:0]  word_count_o;

    imem_loader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .last_i       (last_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .cpu_rst_n_o  (cpu_rst_n_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .word_count_o (word_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory model: captures every write the loader issues.
    logic [31:0] mem [32];
    int          we_cnt = 0;
    always @(posedge clk_i) begin
        if (imem_we_o) begin
            mem[imem_addr_o] <= imem_wdata_o;
            we_cnt           <= we_cnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] bytes;   // byte k at bits [8k+7:8k]
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          cnt;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!byte_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!byte_ready_o) check({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        byte_valid_i = 1'b1;
        byte_i       = b;
        last_i       = last;
        while (!byte_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!byte_ready_o) check("send_byte_timeout", 0, 1);
        tick();
        byte_valid_i = 1'b0;
        last_i       = 1'b0;
    endtask

    task automatic send_pkd(input logic [63:0] pkd, input int n);
        for (int i = 0; i < n; i++) send_byte(pkd[8*i +: 8], (i == n - 1));
    endtask

    // Waits for DONE; checks the final write (if any) sits in the cycle before release.
    task automatic wait_done(input string name, input logic exp_prev_we);
        int   n = 0;
        logic prev_we;
        prev_we = imem_we_o;
        while (!done_o && n < 200) begin
            prev_we = imem_we_o;
            tick();
            n++;
        end
        check({name, "_done"}, done_o, 1);
        check({name, "_release_seq"}, {prev_we, imem_we_o, cpu_rst_n_o}, {exp_prev_we, 1'b0, 1'b1});
    endtask

    function automatic int nonzero_from(input int lo);
        int c = 0;
        for (int i = lo; i < 32; i++) if (mem[i] != 32'h0) c++;
        return c;
    endfunction

    initial begin
        int base;
        vecs[0] = '{64'h4C01001300220823, 8, 32'h00220823, 32'h4C010013, 2};
        vecs[1] = '{64'h0000BBAA44332211, 6, 32'h44332211, 32'h0000BBAA, 2};
        vecs[2] = '{64'h000000000000005A, 1, 32'h0000005A, 32'h00000000, 1};
        vecs[3] = '{64'h00000000EFBEADDE, 4, 32'hEFBEADDE, 32'h00000000, 1};
        vecs[4] = '{64'h0007060504030201, 7, 32'h04030201, 32'h00070605, 2};

        rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00; last_i = 1'b0;
        tick(); tick();
        check("reset_outputs",
              {byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, cpu_rst_n_o, busy_o, done_o, err_o, word_count_o},
              '0);
        rst_i = 1'b0;
        tick();
        check("idle_outputs", {busy_o, done_o, cpu_rst_n_o, byte_ready_o}, 4'b0000);

        // Table-driven program loads, each preceded by a full clear.
        for (int v = 0; v < 5; v++) begin
            base = we_cnt;
            do_start();
            check($sformatf("v%0d_start", v), {busy_o, cpu_rst_n_o, done_o, imem_we_o}, 4'b1001);
            wait_ready($sformatf("v%0d", v));
            check($sformatf("v%0d_clear_writes", v), we_cnt - base, 32);
            send_pkd(vecs[v].bytes, vecs[v].n);
            wait_done($sformatf("v%0d", v), 1'b1);
            check($sformatf("v%0d_w0", v), mem[0], vecs[v].w0);
            check($sformatf("v%0d_w1", v), mem[1], vecs[v].w1);
            check($sformatf("v%0d_rest_zero", v), nonzero_from(2), 0);
            check($sformatf("v%0d_count", v), word_count_o, vecs[v].cnt);
            check($sformatf("v%0d_err", v), err_o, 0);
            check($sformatf("v%0d_total_writes", v), we_cnt - base, 32 + vecs[v].cnt);
        end

        // Stall of 3 cycles between bytes 2 and 3.
        base = we_cnt;
        do_start();
        wait_ready("gap");
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        tick(); tick(); tick();
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b1);
        wait_done("gap", 1'b1);
        check("gap_w0", mem[0], 32'h78563412);
        check("gap_writes", we_cnt - base, 33);
        check("gap_count", word_count_o, 1);

        // Async reset after 5 bytes of a load.
        do_start();
        wait_ready("arst");
        send_pkd(64'h00000000BBAA9988_77, 5);
        check("arst_busy_before", busy_o, 1);
        #3 rst_i = 1'b1;
        #1;
        check("arst_outputs",
              {byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, cpu_rst_n_o, busy_o, done_o, err_o, word_count_o},
              '0);
        tick();
        rst_i = 1'b0;
        tick();
        // Reload; a byte offered in the final CLEAR cycle must not be taken.
        base = we_cnt;
        do_start();
        begin
            int n = 0;
            while (!(imem_we_o && imem_addr_o == 5'd31) && n < 100) begin
                tick();
                n++;
            end
        end
        byte_valid_i = 1'b1; byte_i = 8'hFF; last_i = 1'b1;
        check("entry_ready_low", byte_ready_o, 0);
        tick();
        byte_valid_i = 1'b0; last_i = 1'b0;
        check("entry_byte_ignored", {byte_ready_o, busy_o, done_o}, 3'b110);
        send_pkd(vecs[0].bytes, vecs[0].n);
        wait_done("reload", 1'b1);
        check("reload_w0", mem[0], 32'h00220823);
        check("reload_w1", mem[1], 32'h4C010013);
        check("reload_rest_zero", nonzero_from(2), 0);
        check("reload_writes", we_cnt - base, 34);

        // Overflow: 132 bytes, the last 4 are discarded.
        base = we_cnt;
        do_start();
        wait_ready("ovf");
        for (int i = 0; i < 132; i++) send_byte(8'(i + 1), (i == 131));
        wait_done("ovf", 1'b0);
        check("ovf_err", err_o, 1);
        check("ovf_count", word_count_o, 32);
        check("ovf_w0", mem[0], 32'h04030201);
        check("ovf_w31", mem[31], 32'h807F7E7D);
        check("ovf_writes", we_cnt - base, 64);

        // start_i in DONE clears status; start_i in LOAD is ignored.
        base = we_cnt;
        do_start();
        check("restart_status", {cpu_rst_n_o, err_o, word_count_o, busy_o, done_o}, {1'b0, 1'b0, 6'd0, 1'b1, 1'b0});
        wait_ready("restart");
        check("restart_clear_writes", we_cnt - base, 32);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        do_start();
        check("load_start_ignored", {byte_ready_o, busy_o, imem_we_o}, 3'b110);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hD4, 1'b1);
        wait_done("restart", 1'b1);
        check("restart_w0", mem[0], 32'hD4C3B2A1);
        check("restart_writes", we_cnt - base, 33);
        check("restart_count_err", {word_count_o, err_o}, {6'd1, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
